// File: rtl/nvme_pl_elastic_if.sv
// nvme_pl_elastic_if: one valid/ready beat stream.
// master drives valid/data, slave drives ready.
interface nvme_pl_elastic_if #(
  parameter int width = 128
);
  logic             valid;
  logic             ready;
  logic [width-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/nvme_pl_elastic.sv
// nvme_pl_elastic: DEPTH-entry elastic buffer, optional input stage and bypass.
// Optional per-byte parity: define NVME_PL_ELASTIC_PARITY_EN.
module nvme_pl_elastic #(
  parameter int width  = 128,
  parameter int depth  = 2,
  parameter int stage  = 0,
  parameter int bypass = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  nvme_pl_elastic_if.slave           up,
  nvme_pl_elastic_if.master          dn,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       perr
);

  localparam int CW = $clog2(depth + 1);
  localparam int AW = $clog2(depth);
  localparam int NB = width / 8;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] mem_q [depth];

  logic             bv;
  logic [width-1:0] bd;
  logic             full;
  logic             empty;
  logic             buf_take;
  logic             byp_hit;
  logic             push;
  logic             pop;

  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == '0);

`ifdef NVME_PL_ELASTIC_PARITY_EN
  logic [NB-1:0] bp;
  logic [NB-1:0] par_q [depth];
  logic          perr_q, perr_d;

  function automatic logic [NB-1:0] par_gen(
    input logic [width-1:0] d
  );
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) begin
      p[b] = ^d[8*b +: 8];
    end
    return p;
  endfunction
`endif

  generate
    if (stage != 0) begin : g_stage
      logic             sv_q, sv_d;
      logic [width-1:0] sd_q, sd_d;
      logic             ld;

      assign up.ready = ~flush & (~sv_q | ~full);
      assign ld       = up.valid & up.ready;

      always_comb begin
        sv_d = sv_q;
        sd_d = sd_q;
        if (flush) begin
          sv_d = 1'b0;
        end else if (ld) begin
          sv_d = 1'b1;
          sd_d = up.data;
        end else if (buf_take) begin
          sv_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sv_q <= 1'b0;
        end else begin
          sv_q <= sv_d;
        end
      end

      always_ff @(posedge clk) begin
        sd_q <= sd_d;
      end

      assign bv = sv_q;
      assign bd = sd_q;

`ifdef NVME_PL_ELASTIC_PARITY_EN
      // Parity follows the beat from the stage into the store.
      logic [NB-1:0] sp_q, sp_d;

      always_comb begin
        sp_d = sp_q;
        if (ld) begin
          sp_d = par_gen(up.data);
        end
      end

      always_ff @(posedge clk) begin
        sp_q <= sp_d;
      end

      assign bp = sp_q;
`endif
    end else begin : g_direct
      assign up.ready = ~flush & ~full;
      assign bv       = up.valid;
      assign bd       = up.data;
`ifdef NVME_PL_ELASTIC_PARITY_EN
      assign bp       = par_gen(up.data);
`endif
    end
  endgenerate

  // Empty buffer with a valid input beat goes straight to the output.
  assign byp_hit  = (bypass != 0) & empty & bv;
  assign buf_take = bv & ~full & ~flush;

  assign dn.valid = reset_n & ~flush & (~empty | byp_hit);
  assign dn.data  = ((bypass != 0) && empty) ? bd : mem_q[rd_ptr_q];

  assign push = buf_take & ~(byp_hit & dn.ready);
  assign pop  = dn.valid & dn.ready & ~empty;

  function automatic logic [AW-1:0] ptr_nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_nxt(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_nxt(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bd;
    end
  end

  assign count = count_q;

`ifdef NVME_PL_ELASTIC_PARITY_EN
  always_ff @(posedge clk) begin
    if (push) begin
      par_q[wr_ptr_q] <= bp;
    end
  end

  // Only beats leaving the store are checked; bypass beats never are.
  always_comb begin
    perr_d = 1'b0;
    if (pop) begin
      perr_d = (par_gen(mem_q[rd_ptr_q]) != par_q[rd_ptr_q]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_nvme_pl_elastic.sv
// tb_nvme_pl_elastic: three configurations against a queue-based model.
// a: depth4/bypass, b: depth3/bypass, c: depth3/stage/no-bypass.
module tb_nvme_pl_elastic;
  localparam int W = 32;
  localparam int N = 3;

  int dep [N] = '{4, 3, 3};
  bit stg [N] = '{1'b0, 1'b0, 1'b1};
  bit byp [N] = '{1'b1, 1'b1, 1'b0};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush [N];
  logic         vin   [N];
  logic         rin   [N];
  logic [W-1:0] din   [N];

  logic         o_rdy  [N];
  logic         o_vld  [N];
  logic         o_perr [N];
  logic [W-1:0] o_dat  [N];
  int           o_cnt  [N];
  logic [2:0]   cnt_a;
  logic [1:0]   cnt_b;
  logic [1:0]   cnt_c;

  logic [W-1:0] mq [N][$];
  bit           sv [N];
  logic [W-1:0] sd [N];
  bit           acc [N];
  bit           hold [N];
  bit           exp_perr [N];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nvme_pl_elastic_if #(.width(W)) up_a(), dn_a();
  nvme_pl_elastic_if #(.width(W)) up_b(), dn_b();
  nvme_pl_elastic_if #(.width(W)) up_c(), dn_c();

  assign up_a.valid = vin[0];
  assign up_a.data  = din[0];
  assign dn_a.ready = rin[0];
  assign up_b.valid = vin[1];
  assign up_b.data  = din[1];
  assign dn_b.ready = rin[1];
  assign up_c.valid = vin[2];
  assign up_c.data  = din[2];
  assign dn_c.ready = rin[2];

  assign o_rdy[0] = up_a.ready;
  assign o_vld[0] = dn_a.valid;
  assign o_dat[0] = dn_a.data;
  assign o_cnt[0] = int'(cnt_a);
  assign o_rdy[1] = up_b.ready;
  assign o_vld[1] = dn_b.valid;
  assign o_dat[1] = dn_b.data;
  assign o_cnt[1] = int'(cnt_b);
  assign o_rdy[2] = up_c.ready;
  assign o_vld[2] = dn_c.valid;
  assign o_dat[2] = dn_c.data;
  assign o_cnt[2] = int'(cnt_c);

  nvme_pl_elastic #(.width(W), .depth(4), .stage(0), .bypass(1)) u_a (
    .clk(clk), .reset_n(reset_n), .flush(flush[0]),
    .up(up_a), .dn(dn_a), .count(cnt_a), .perr(o_perr[0])
  );

  nvme_pl_elastic #(.width(W), .depth(3), .stage(0), .bypass(1)) u_b (
    .clk(clk), .reset_n(reset_n), .flush(flush[1]),
    .up(up_b), .dn(dn_b), .count(cnt_b), .perr(o_perr[1])
  );

  nvme_pl_elastic #(.width(W), .depth(3), .stage(1), .bypass(0)) u_c (
    .clk(clk), .reset_n(reset_n), .flush(flush[2]),
    .up(up_c), .dn(dn_c), .count(cnt_c), .perr(o_perr[2])
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare one DUT to the model, then advance the model past the edge.
  task automatic eval_dut(input int i);
    int           n;
    bit           bv, e_rdy, e_vld, up_x, dn_x, take, bhit;
    logic [W-1:0] bd, e_dat;
    n     = mq[i].size();
    bv    = stg[i] ? sv[i] : vin[i];
    bd    = stg[i] ? sd[i] : din[i];
    e_rdy = !flush[i] && (stg[i] ? (!sv[i] || n != dep[i]) : (n != dep[i]));
    e_vld = !flush[i] && (n != 0 || (byp[i] && bv));
    e_dat = (n != 0) ? mq[i][0] : bd;
    chk($sformatf("d%0d rdy", i), o_rdy[i], e_rdy);
    chk($sformatf("d%0d vld", i), o_vld[i], e_vld);
    chk($sformatf("d%0d cnt", i), o_cnt[i], n);
    chk($sformatf("d%0d perr", i), o_perr[i], exp_perr[i]);
    if (e_vld) chk($sformatf("d%0d data", i), o_dat[i], e_dat);
    acc[i]  = vin[i] && e_rdy;
    hold[i] = vin[i] && !e_rdy;
    if (flush[i]) begin
      mq[i].delete();
      sv[i] = 1'b0;
      return;
    end
    up_x = vin[i] && e_rdy;
    dn_x = e_vld && rin[i];
    take = bv && (n != dep[i]);
    bhit = byp[i] && n == 0 && bv && rin[i];
    if (dn_x && n != 0) void'(mq[i].pop_front());
    if (take && !bhit) mq[i].push_back(bd);
    if (stg[i]) begin
      if (up_x) begin
        sv[i] = 1'b1;
        sd[i] = din[i];
      end else if (take) begin
        sv[i] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      vin[i]   = 1'b0;
      rin[i]   = 1'b0;
      flush[i] = 1'b0;
      din[i]   = $urandom;
    end
  endtask

  task automatic settle();
    #1;
    for (int i = 0; i < N; i++) eval_dut(i);
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) flush[i] = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst d%0d rdy", i), o_rdy[i], 1'b1);
      chk($sformatf("rst d%0d vld", i), o_vld[i], 1'b0);
      chk($sformatf("rst d%0d cnt", i), o_cnt[i], 0);
      chk($sformatf("rst d%0d perr", i), o_perr[i], 1'b0);
      mq[i].delete();
      sv[i]       = 1'b0;
      hold[i]     = 1'b0;
      exp_perr[i] = 1'b0;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int k;
    idle();
    do_reset();

    // stream through empty bypass buffer, zero latency
    for (int c = 1; c <= 16; c++) begin
      idle();
      vin[0] = 1'b1;
      din[0] = W'(c);
      rin[0] = 1'b1;
      settle();
      chk("t1 lat0", o_dat[0], W'(c));
      chk("t1 cnt0", o_cnt[0], 0);
      adv();
    end

    // fill to full with backpressure, then drain
    k = 0;
    for (int c = 0; c < 16; c++) begin
      idle();
      vin[0] = (k < 6);
      din[0] = W'(32'hA0 + k);
      rin[0] = (c >= 6);
      settle();
      if (c == 5) begin
        chk("t2 full cnt", o_cnt[0], 4);
        chk("t2 full rdy", o_rdy[0], 1'b0);
      end
      if (acc[0]) k++;
      adv();
    end
    chk("t2 all taken", k, 6);
    chk("t2 drained", o_cnt[0], 0);

    // staged, unbypassed: valid_out two cycles after valid_in
    for (int c = 0; c < 5; c++) begin
      idle();
      vin[2] = (c == 0);
      din[2] = 32'h55;
      rin[2] = 1'b1;
      settle();
      chk("t4 vld", o_vld[2], (c == 2));
      if (c == 2) chk("t4 data", o_dat[2], 32'h55);
      adv();
    end

    // flush a full depth-3 buffer while both sides are willing
    for (int c = 0; c < 3; c++) begin
      idle();
      vin[1] = 1'b1;
      din[1] = W'(32'hB0 + c);
      settle();
      adv();
    end
    idle();
    settle();
    chk("t5 cnt3", o_cnt[1], 3);
    idle();
    flush[1] = 1'b1;
    vin[1]   = 1'b1;
    din[1]   = 32'hC0;
    rin[1]   = 1'b1;
    settle();
    chk("t5 fl rdy", o_rdy[1], 1'b0);
    chk("t5 fl vld", o_vld[1], 1'b0);
    adv();
    idle();
    vin[1] = 1'b1;
    din[1] = 32'hC1;
    rin[1] = 1'b1;
    settle();
    chk("t5 post cnt", o_cnt[1], 0);
    chk("t5 post vld", o_vld[1], 1'b1);
    chk("t5 post data", o_dat[1], 32'hC1);
    adv();

`ifdef NVME_PL_ELASTIC_PARITY_EN
    idle();
    do_reset();
    idle();
    vin[0] = 1'b1;
    din[0] = 32'h1234;
    settle();
    adv();
    u_a.mem_q[0] = u_a.mem_q[0] ^ 32'h8;
    mq[0][0]     = mq[0][0] ^ 32'h8;
    idle();
    rin[0] = 1'b1;
    settle();
    adv();
    idle();
    exp_perr[0] = 1'b1;
    settle();
    adv();
    exp_perr[0] = 1'b0;
    idle();
    settle();
    adv();
`endif

    // random traffic, mid-run reset
    idle();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          vin[i] = ($urandom_range(0, 2) != 0);
          din[i] = $urandom;
        end
        rin[i]   = (c < 5000) ? ($urandom_range(0, 2) == 0)
                              : ($urandom_range(0, 3) != 0);
        flush[i] = ($urandom_range(0, 99) == 0);
      end
      if (c == 5000) begin
        do_reset();
      end else begin
        settle();
        for (int i = 0; i < N; i++) begin
          chk($sformatf("d%0d cnt bound", i), (o_cnt[i] <= dep[i]), 1'b1);
        end
        adv();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
